hdmi_src_arbiter: RTL and testbench



---
 rtl/hdmi_src_arbiter.sv | 116 +++++++++++
 tb/tb_hdmi_src_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hdmi_src_arbiter.sv
// Frame-synchronous two-source pixel arbiter: ownership of the HDMI pixel path
// changes only at one blanking row per frame, with minimum hold and round-robin ties.
module hdmi_src_arbiter #(
   parameter int unsigned ROW_W      = 10,
   parameter int unsigned SWITCH_ROW = 720,
   parameter int unsigned MIN_FRAMES = 4
) (
   input  logic             pix_clk,
   input  logic             reset,
   input  logic [ROW_W-1:0] row,
   input  logic             req0,
   input  logic             req1,
   input  logic [7:0]       r0,
   input  logic [7:0]       g0,
   input  logic [7:0]       b0,
   input  logic [7:0]       r1,
   input  logic [7:0]       g1,
   input  logic [7:0]       b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b,
   output logic             frame_tick,
   output logic             switched
);

   localparam int unsigned HOLD_W = $clog2(MIN_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t            state, state_nxt;
   logic [ROW_W-1:0]  row_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic              last_owner;
   logic              boundary;
   logic              hold_ok;

   // row_q resets to 0, so a row already at SWITCH_ROW on reset release still counts
   assign boundary = (row == ROW_W'(SWITCH_ROW)) && (row_q != ROW_W'(SWITCH_ROW));
   assign hold_ok  = (32'(hold_cnt) + 32'd1) >= 32'(MIN_FRAMES);

   always_ff @(posedge pix_clk) begin
      if (reset) begin
         state      <= IDLE;
         row_q      <= '0;
         hold_cnt   <= '0;
         last_owner <= 1'b1;
         frame_tick <= 1'b0;
         switched   <= 1'b0;
      end else begin
         row_q      <= row;
         state      <= state_nxt;
         frame_tick <= boundary;
         switched   <= boundary && (state_nxt != state);
         if ((state_nxt != state) && (state_nxt != IDLE)) begin
            hold_cnt   <= '0;
            last_owner <= (state_nxt == OWN1);
         end else if (boundary && (state_nxt == state) && (state != IDLE) &&
                      (hold_cnt != HOLD_W'(MIN_FRAMES))) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (boundary) begin
         case (state)
            IDLE: begin
               if (req0 && req1)
                  state_nxt = last_owner ? OWN0 : OWN1;
               else if (req0)
                  state_nxt = OWN0;
               else if (req1)
                  state_nxt = OWN1;
            end
            OWN0: begin
               if (!req0)
                  state_nxt = req1 ? OWN1 : IDLE;
               else if (req1 && hold_ok)
                  state_nxt = OWN1;
            end
            OWN1: begin
               if (!req1)
                  state_nxt = req0 ? OWN0 : IDLE;
               else if (req0 && hold_ok)
                  state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      gnt0 = (state == OWN0);
      gnt1 = (state == OWN1);
      r    = '0;
      g    = '0;
      b    = '0;
      case (state)
         OWN0: begin
            r = r0;
            g = g0;
            b = b0;
         end
         OWN1: begin
            r = r1;
            g = g1;
            b = b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hdmi_src_arbiter.sv
// Scoreboard bench: two arbiters (MIN_FRAMES=4 and 1) share directed per-frame stimulus;
// expected post-boundary outputs are queued and checked when frame_tick appears.
module tb_hdmi_src_arbiter;

   logic       pix_clk = 1'b0;
   logic       reset;
   logic [9:0] row;
   logic       req0, req1;
   logic [7:0] r0, g0, b0, r1, g1, b1;

   logic       gnt0_a, gnt1_a, frame_tick_a, switched_a;
   logic [7:0] r_a, g_a, b_a;
   logic       gnt0_b, gnt1_b, frame_tick_b, switched_b;
   logic [7:0] r_b, g_b, b_b;

   int checks = 0;
   int errors = 0;

   logic [26:0] qa[$];
   logic [26:0] qb[$];

   always #5 pix_clk = ~pix_clk;

   hdmi_src_arbiter #(.ROW_W(10), .SWITCH_ROW(720), .MIN_FRAMES(4)) u_a (
      .pix_clk(pix_clk), .reset(reset), .row(row), .req0(req0), .req1(req1),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .r(r_a), .g(g_a), .b(b_a),
      .frame_tick(frame_tick_a), .switched(switched_a)
   );

   hdmi_src_arbiter #(.ROW_W(10), .SWITCH_ROW(720), .MIN_FRAMES(1)) u_b (
      .pix_clk(pix_clk), .reset(reset), .row(row), .req0(req0), .req1(req1),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .r(r_b), .g(g_b), .b(b_b),
      .frame_tick(frame_tick_b), .switched(switched_b)
   );

   // {gnt0, gnt1, switched} -> packed expectation including the selected pixel
   function automatic logic [26:0] mk(input logic [2:0] e);
      logic [23:0] px;
      px = e[2] ? 24'h112233 : (e[1] ? 24'h445566 : 24'h000000);
      return {e, px};
   endfunction

   task automatic compare(input string name, input logic [26:0] act, input logic [26:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got gnt=%b%b sw=%b rgb=%h, expected gnt=%b%b sw=%b rgb=%h",
                  name, act[26], act[25], act[24], act[23:0], exp[26], exp[25], exp[24], exp[23:0]);
      end
   endtask

   function automatic logic [26:0] cur_a();
      return {gnt0_a, gnt1_a, switched_a, r_a, g_a, b_a};
   endfunction

   function automatic logic [26:0] cur_b();
      return {gnt0_b, gnt1_b, switched_b, r_b, g_b, b_b};
   endfunction

   always @(negedge pix_clk) begin
      if (gnt0_a && gnt1_a) begin
         checks++; errors++;
         $display("FAIL excl_a: gnt0=1 gnt1=1, expected at most one");
      end
      if (gnt0_b && gnt1_b) begin
         checks++; errors++;
         $display("FAIL excl_b: gnt0=1 gnt1=1, expected at most one");
      end
      if (frame_tick_a) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL tick_a: frame_tick=1, expected no pulse");
         end else
            compare("frame_a", cur_a(), qa.pop_front());
      end else if (switched_a) begin
         checks++; errors++;
         $display("FAIL sw_a: switched=1 without frame_tick, expected 0");
      end
      if (frame_tick_b) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL tick_b: frame_tick=1, expected no pulse");
         end else
            compare("frame_b", cur_b(), qb.pop_front());
      end else if (switched_b) begin
         checks++; errors++;
         $display("FAIL sw_b: switched=1 without frame_tick, expected 0");
      end
   end

   // One frame: requests set at row 100, expectations queued as row 720 is driven
   task automatic frame(input logic q0, input logic q1,
                        input logic [2:0] ea, input logic [2:0] eb, input bit rst_mid);
      for (int i = 0; i < 750; i++) begin
         @(negedge pix_clk);
         row = 10'(i);
         if (i == 100) begin
            req0 = q0;
            req1 = q1;
         end
         if (rst_mid && i == 300) reset = 1'b1;
         if (rst_mid && i == 301) begin
            compare("midrst_a", cur_a(), 27'h0);
            compare("midrst_b", cur_b(), 27'h0);
            reset = 1'b0;
         end
         if (rst_mid && i == 719) compare("pre_regrant_a", cur_a(), 27'h0);
         if (i == 720) begin
            qa.push_back(mk(ea));
            qb.push_back(mk(eb));
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      row   = '0;
      req0  = 1'b0;
      req1  = 1'b0;
      r0 = 8'h11; g0 = 8'h22; b0 = 8'h33;
      r1 = 8'h44; g1 = 8'h55; b1 = 8'h66;
      repeat (3) @(negedge pix_clk);
      compare("reset_a", {cur_a()}, 27'h0);
      compare("reset_b", {cur_b()}, 27'h0);
      checks++;
      if (frame_tick_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b, expected 0", frame_tick_a);
      end
      reset = 1'b0;

      //     req0  req1  A:{g0,g1,sw} B:{g0,g1,sw}
      frame(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);   // idle
      frame(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      frame(1'b1, 1'b0, 3'b101, 3'b101, 1'b0);   // single request
      frame(1'b1, 1'b1, 3'b100, 3'b011, 1'b0);   // hold on A, alternate on B
      frame(1'b1, 1'b1, 3'b100, 3'b101, 1'b0);
      frame(1'b1, 1'b1, 3'b100, 3'b011, 1'b0);
      frame(1'b1, 1'b1, 3'b011, 3'b101, 1'b0);   // 4th boundary after grant
      frame(1'b1, 1'b1, 3'b010, 3'b011, 1'b0);
      frame(1'b0, 1'b1, 3'b010, 3'b010, 1'b0);
      frame(1'b1, 1'b0, 3'b101, 3'b101, 1'b0);   // direct handover
      frame(1'b0, 1'b0, 3'b001, 3'b001, 1'b0);   // release to idle

      @(negedge pix_clk);
      reset = 1'b1;
      repeat (3) @(negedge pix_clk);
      reset = 1'b0;
      frame(1'b1, 1'b1, 3'b101, 3'b101, 1'b0);   // tie after reset -> source 0
      frame(1'b0, 1'b1, 3'b011, 3'b011, 1'b0);   // owner drops -> handover, no idle
      frame(1'b0, 1'b1, 3'b011, 3'b011, 1'b1);   // mid-frame reset, regrant at 720
      frame(1'b0, 1'b0, 3'b001, 3'b001, 1'b0);

      repeat (5) @(negedge pix_clk);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL drain: pending a=%0d b=%0d, expected 0 0", qa.size(), qb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
